icache: RTL and testbench

Direct-mapped, read-only instruction cache between the PC/fetch stage and the block-organised instruction memory. It is the responder to the CPU's fetch requests: it takes the current PC, returns the 32-bit instruction and stalls the pipeline through BUSYWAIT on a miss. It is also the initiator of 128-bit block reads to instruction memory. The protocol mirrors the data-side cache, without writes or dirty handling.

---
 rtl/icache_if.sv | 31 +++
 rtl/icache.sv | 95 +++++++++
 tb/tb_icache.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and instruction-memory-side signals of the instruction cache.
// The cache uses the slave view; the CPU/memory environment uses the master view.
interface icache_if;
  logic [31:0]  address;
  logic [31:0]  instruction;
  logic         busywait;
  logic         imem_read;
  logic [27:0]  imem_block_addr;
  logic [127:0] imem_readdata;
  logic         imem_busywait;

  modport slave (
    input  address,
    input  imem_readdata,
    input  imem_busywait,
    output instruction,
    output busywait,
    output imem_read,
    output imem_block_addr
  );

  modport master (
    output address,
    output imem_readdata,
    output imem_busywait,
    input  instruction,
    input  busywait,
    input  imem_read,
    input  imem_block_addr
  );
endinterface

// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 16-byte lines and 128-bit
// block refills from instruction memory.
//
// state    | meaning
// IDLE     | lookup; hit returns the word, miss latches block and requests refill
// MEM_READ | block read pending, waits for imem_busywait low
// UPDATE   | line written, one cycle before the lookup is re-evaluated
module icache #(
  parameter int IDX_BITS = 3
) (
  input logic   clk,
  input logic   rst_n,
  icache_if.slave bus
);
  localparam int LINES    = 1 << IDX_BITS;
  localparam int TAG_BITS = 28 - IDX_BITS;

  typedef enum logic [1:0] {IDLE, MEM_READ, UPDATE} state_t;

  state_t               state;
  logic [LINES-1:0]     valid;
  logic [TAG_BITS-1:0]  tag_mem  [LINES];
  logic [127:0]         data_mem [LINES];
  logic [27:0]          blk_q;
  logic                 imem_read_q;

  logic [1:0]           offset;
  logic [IDX_BITS-1:0]  idx;
  logic [TAG_BITS-1:0]  tag;
  logic                 hit;
  logic [IDX_BITS-1:0]  fill_idx;
  logic [TAG_BITS-1:0]  fill_tag;
  logic                 refill_done;
  logic [31:0]          line_word;
  logic                 unused_addr_bits;

  assign offset           = bus.address[3:2];
  assign idx              = bus.address[4+IDX_BITS-1:4];
  assign tag              = bus.address[31:4+IDX_BITS];
  assign unused_addr_bits = ^bus.address[1:0];

  assign hit = valid[idx] && (tag_mem[idx] == tag);

  assign fill_idx    = blk_q[IDX_BITS-1:0];
  assign fill_tag    = blk_q[27:IDX_BITS];
  assign refill_done = (state == MEM_READ) && !bus.imem_busywait;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      valid       <= '0;
      blk_q       <= '0;
      imem_read_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!hit) begin
            blk_q       <= bus.address[31:4];
            imem_read_q <= 1'b1;
            state       <= MEM_READ;
          end
        end
        MEM_READ: begin
          if (!bus.imem_busywait) begin
            valid[fill_idx] <= 1'b1;
            imem_read_q     <= 1'b0;
            state           <= UPDATE;
          end
        end
        UPDATE: begin
          state <= IDLE;
        end
        default: begin
          imem_read_q <= 1'b0;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Tag/data need no reset: the valid bits alone decide whether a line is usable.
  always_ff @(posedge clk) begin
    if (refill_done) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= bus.imem_readdata;
    end
  end

  assign line_word = data_mem[idx][{offset, 5'b0} +: 32];

  assign bus.imem_read       = imem_read_q;
  assign bus.imem_block_addr = blk_q;
  assign bus.busywait        = rst_n && ((state != IDLE) || !hit);
  assign bus.instruction     = rst_n ? line_word : 32'h0;
endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: memory model with programmable read latency and
// hand-computed expected instructions, busywait and refill counts.
module tb_icache;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   mem_lat = 1;
  int   rd_cnt = 0;
  int   n_tests = 0;
  int   n_fail = 0;

  icache_if bus ();

  icache #(.IDX_BITS(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] blk_data(input logic [27:0] b);
    logic [127:0] d;
    if (b == 28'h0) begin
      d = {32'h00300193, 32'h00200113, 32'h00100093, 32'h00000013};
    end else begin
      for (int n = 0; n < 4; n++) d[32*n +: 32] = {4'hA, b[23:0], 4'(n)};
    end
    return d;
  endfunction

  always @(posedge clk) rd_cnt <= bus.imem_read ? rd_cnt + 1 : 0;
  assign bus.imem_busywait = bus.imem_read && (rd_cnt != mem_lat - 1);
  assign bus.imem_readdata = blk_data(bus.imem_block_addr);

  task automatic fetch(input logic [31:0] a, output int bw, output int rd,
                       output logic [27:0] blk);
    @(negedge clk);
    bus.address = a;
    #1;
    bw  = 0;
    rd  = 0;
    blk = 28'hFFFFFFF;
    while (bus.busywait && bw < 60) begin
      bw++;
      if (bus.imem_read) begin
        rd++;
        blk = bus.imem_block_addr;
      end
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    bus.address = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_tests++;
    if (bus.busywait !== 1'b0) begin
      n_fail++; $display("FAIL reset_busywait got %b exp 0", bus.busywait);
    end
    n_tests++;
    if (bus.imem_read !== 1'b0) begin
      n_fail++; $display("FAIL reset_imem_read got %b exp 0", bus.imem_read);
    end
    n_tests++;
    if (bus.instruction !== 32'h0) begin
      n_fail++; $display("FAIL reset_instruction got %h exp 00000000", bus.instruction);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    int bw, rd;
    logic [27:0] blk;
    mem_lat = 5;
    fetch(32'h0, bw, rd, blk);
    n_tests++;
    if (bw !== 7) begin n_fail++; $display("FAIL cold_busywait_cycles got %0d exp 7", bw); end
    n_tests++;
    if (rd !== 5) begin n_fail++; $display("FAIL cold_imem_read_cycles got %0d exp 5", rd); end
    n_tests++;
    if (blk !== 28'h0) begin n_fail++; $display("FAIL cold_block_addr got %h exp 0", blk); end
    n_tests++;
    if (bus.instruction !== 32'h00000013) begin
      n_fail++; $display("FAIL cold_instruction got %h exp 00000013", bus.instruction);
    end
  endtask

  task automatic test_same_block();
    logic [31:0] addrs [3] = '{32'h4, 32'h8, 32'hC};
    logic [31:0] exps  [3] = '{32'h00100093, 32'h00200113, 32'h00300193};
    int bw, rd;
    logic [27:0] blk;
    for (int i = 0; i < 3; i++) begin
      fetch(addrs[i], bw, rd, blk);
      n_tests++;
      if (bw !== 0 || rd !== 0) begin
        n_fail++; $display("FAIL same_block_stall addr %h busy %0d rd %0d exp 0 0", addrs[i], bw, rd);
      end
      n_tests++;
      if (bus.instruction !== exps[i]) begin
        n_fail++; $display("FAIL same_block_instr addr %h got %h exp %h", addrs[i], bus.instruction, exps[i]);
      end
    end
  endtask

  task automatic test_conflict();
    int bw, rd;
    logic [27:0] blk;
    mem_lat = 2;
    fetch(32'h80, bw, rd, blk);
    n_tests++;
    if (bw !== 4 || rd !== 2) begin
      n_fail++; $display("FAIL conflict_miss busy %0d rd %0d exp 4 2", bw, rd);
    end
    n_tests++;
    if (blk !== 28'h8) begin n_fail++; $display("FAIL conflict_block_addr got %h exp 8", blk); end
    n_tests++;
    if (bus.instruction !== 32'hA0000080) begin
      n_fail++; $display("FAIL conflict_instr got %h exp a0000080", bus.instruction);
    end
    fetch(32'h84, bw, rd, blk);
    n_tests++;
    if (bw !== 0 || bus.instruction !== 32'hA0000081) begin
      n_fail++; $display("FAIL conflict_hit busy %0d instr %h exp 0 a0000081", bw, bus.instruction);
    end
    fetch(32'h0, bw, rd, blk);
    n_tests++;
    if (bw !== 4 || blk !== 28'h0) begin
      n_fail++; $display("FAIL evicted_refetch busy %0d blk %h exp 4 0", bw, blk);
    end
    n_tests++;
    if (bus.instruction !== 32'h00000013) begin
      n_fail++; $display("FAIL evicted_instr got %h exp 00000013", bus.instruction);
    end
  endtask

  task automatic test_index_indep();
    logic [31:0] addrs [5] = '{32'h14, 32'h28, 32'h1C, 32'h24, 32'h0};
    logic [31:0] exps  [5] = '{32'hA0000011, 32'hA0000022, 32'hA0000013, 32'hA0000021, 32'h00000013};
    int bw, rd;
    logic [27:0] blk;
    mem_lat = 1;
    fetch(32'h10, bw, rd, blk);
    n_tests++;
    if (bw !== 3 || rd !== 1 || blk !== 28'h1) begin
      n_fail++; $display("FAIL fill_10 busy %0d rd %0d blk %h exp 3 1 1", bw, rd, blk);
    end
    fetch(32'h20, bw, rd, blk);
    n_tests++;
    if (bw !== 3 || blk !== 28'h2) begin
      n_fail++; $display("FAIL fill_20 busy %0d blk %h exp 3 2", bw, blk);
    end
    for (int i = 0; i < 5; i++) begin
      fetch(addrs[i], bw, rd, blk);
      n_tests++;
      if (bw !== 0 || bus.instruction !== exps[i]) begin
        n_fail++;
        $display("FAIL index_hit addr %h busy %0d instr %h exp 0 %h", addrs[i], bw, bus.instruction, exps[i]);
      end
    end
  endtask

  task automatic test_reset_mid_refill();
    int bw, rd;
    logic [27:0] blk;
    mem_lat = 10;
    @(negedge clk);
    bus.address = 32'h60;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (bus.imem_read !== 1'b0 || bus.busywait !== 1'b0) begin
      n_fail++; $display("FAIL mid_refill_reset rd %b busy %b exp 0 0", bus.imem_read, bus.busywait);
    end
    mem_lat = 1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    fetch(32'h60, bw, rd, blk);
    n_tests++;
    if (bw !== 3 || blk !== 28'h6) begin
      n_fail++; $display("FAIL abandoned_line_refetch busy %0d blk %h exp 3 6", bw, blk);
    end
    n_tests++;
    if (bus.instruction !== 32'hA0000060) begin
      n_fail++; $display("FAIL abandoned_line_instr got %h exp a0000060", bus.instruction);
    end
    fetch(32'h0, bw, rd, blk);
    n_tests++;
    if (bw !== 3 || blk !== 28'h0) begin
      n_fail++; $display("FAIL stale_valid_cleared busy %0d blk %h exp 3 0", bw, blk);
    end
  endtask

  task automatic test_addr_change();
    int bw, rd;
    logic [27:0] first_blk, last_blk;
    logic seen;
    mem_lat = 3;
    seen = 1'b0;
    first_blk = 28'hFFFFFFF;
    last_blk = 28'hFFFFFFF;
    @(negedge clk);
    bus.address = 32'h40;
    #1;
    bw = 0;
    while (bus.busywait && bw < 60) begin
      bw++;
      if (bus.imem_read) begin
        if (!seen) first_blk = bus.imem_block_addr;
        seen = 1'b1;
        last_blk = bus.imem_block_addr;
      end
      @(negedge clk);
      if (bw == 1) bus.address = 32'h100;
      #1;
    end
    n_tests++;
    if (first_blk !== 28'h4) begin
      n_fail++; $display("FAIL latched_block got %h exp 4", first_blk);
    end
    n_tests++;
    if (last_blk !== 28'h10) begin
      n_fail++; $display("FAIL second_miss_block got %h exp 10", last_blk);
    end
    n_tests++;
    if (bw !== 10) begin n_fail++; $display("FAIL chained_busywait_cycles got %0d exp 10", bw); end
    n_tests++;
    if (bus.instruction !== 32'hA0000100) begin
      n_fail++; $display("FAIL new_addr_instr got %h exp a0000100", bus.instruction);
    end
    fetch(32'h40, bw, rd, last_blk);
    n_tests++;
    if (bw !== 0 || bus.instruction !== 32'hA0000040) begin
      n_fail++; $display("FAIL old_line_hit busy %0d instr %h exp 0 a0000040", bw, bus.instruction);
    end
  endtask

  initial begin
    bus.address = 32'h0;
    test_reset();
    test_cold_miss();
    test_same_block();
    test_conflict();
    test_index_indep();
    test_reset_mid_refill();
    test_addr_change();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
